aes_subbytes_byte_sequencer: RTL and testbench
==============================================

Name: aes_subbytes_byte_sequencer

Overview:
Feeds a full 128-bit AES state, one byte per cycle, through a single shared dual-mode (forward/inverse) byte S-box and reassembles the substituted state. The S-box is external: this block drives its input byte and mode, then consumes its output byte. It sits between round-state storage and the S-box core, and uses valid/ready handshakes on both the state input and the state output.

Parameters:
SBOX_LAT, 0, number of register stages between sbox_i and sbox_o in the attached S-box (legal 0..3).

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  input state valid
in_ready  output  1  block can accept a state
in_data  input  128  input state; byte k = in_data[127-8k -: 8]
in_inverse  input  1  1 = inverse S-box, sampled with in_data
out_valid  output  1  substituted state available
out_ready  input  1  consumer accepts out_data
out_data  output  128  substituted state; same byte mapping as in_data
busy  output  1  high in RUN or DONE
sbox_i  output  8  byte to S-box
sbox_inverse  output  1  mode to S-box
sbox_o  input  8  S-box result, SBOX_LAT cycles after sbox_i

Behaviour:
- Reset: one clock; reset is synchronous and active-low (rst_n sampled on rising clk). Reset has priority over all other events.
  - State returns to IDLE.
  - Issue counter, collect counter and all valid-token pipeline stages are cleared.
  - Output values during reset: in_ready=0, out_valid=0, busy=0, out_data=0, sbox_i=0, sbox_inverse=0.
  - in_ready goes to 1 in the first cycle after rst_n is released.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - On in_valid&in_ready: latch in_data and in_inverse, clear both counters, go to RUN.
- RUN: in_ready=0.
  - Issue phase: sbox_i = latched byte[issue_cnt]; issue_cnt increments 0..15, one byte per cycle with no stalls, then stops.
  - A valid token travels through a SBOX_LAT-deep shift register alongside each issued byte.
  - Collect phase: when a token emerges, write sbox_o into out_data byte[collect_cnt] and increment collect_cnt.
  - When byte 15 is collected, go to DONE.
- Latency: with the acceptance edge as cycle 0, out_valid rises in cycle 17+SBOX_LAT.
  - SBOX_LAT=0 gives cycle 17.
  - Throughput is one state per 17+SBOX_LAT cycles plus the out handshake cycle.
- DONE: out_valid=1; out_data is held stable until out_valid&out_ready.
  - On that handshake, go to IDLE. in_ready returns the next cycle; there is no same-cycle accept of a new state.
- out_data keeps its last value in IDLE. Bytes are overwritten progressively during RUN; consumers must sample only on out_valid.
- sbox_inverse = latched inverse for the whole of RUN, including drain cycles after the last issue.
- sbox_i after the 16th issue, and outside RUN: holds the last issued byte, unless the optional feature is enabled.
- Counters are 4-bit plus a done flag; there is no wrap-around. Issue beyond 16 bytes is structurally impossible.
- Reset asserted mid-RUN or mid-DONE: the state in flight is discarded and no out_valid is produced.
  - Results still in the S-box pipeline return as sbox_o after reset and must be ignored, because the tokens were cleared.
- in_valid while busy is ignored (in_ready=0); the upstream side must hold it.

Optional Feature:
- Macro SUBBYTES_IDLE_ZERO_EN.
- Defined: sbox_i is forced to 8'h00 in every cycle in which no byte is issued (IDLE, DONE, RUN drain cycles). This avoids holding secret bytes on the S-box input. Cost: one AND gate per bit, no latency change.
- Undefined: sbox_i holds its last issued value in those cycles.

Test Plan:
- Forward, SBOX_LAT=0: in_data=00112233445566778899aabbccddeeff, in_inverse=0 -> out_data=638293c31bfc33f5c4eeacea4bc12816, out_valid exactly at cycle 17.
- Inverse, SBOX_LAT=2: in_data=638293c31bfc33f5c4eeacea4bc12816, in_inverse=1 -> out_data=00112233445566778899aabbccddeeff at cycle 19; sbox_inverse=1 throughout RUN.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid, and pulse in_valid with all-zero data during that time -> out_data stays stable, in_ready=0, the new state is not accepted; after out_ready=1, the all-zero state is accepted and returns 6363...63.
- Back-to-back: in_valid held high with two states -> second acceptance occurs 1 cycle after the first out handshake; both results correct.
- Reset mid-RUN (rst_n=0 at cycle 8, SBOX_LAT=3) -> all outputs zero during reset, no out_valid afterwards, next state processed correctly with no stale bytes.
- With SUBBYTES_IDLE_ZERO_EN: sbox_i==0 in every non-issue cycle; without it, sbox_i==last issued byte in those cycles.

Source files
------------

// File: rtl/aes_subbytes_byte_sequencer.sv
// aes_subbytes_byte_sequencer
// Feeds a 128-bit AES state one byte per cycle through an external shared
// forward/inverse S-box and reassembles the substituted state.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready/in_data  state input handshake (byte k = in_data[127-8k -: 8])
//   in_inverse                 1 = inverse S-box, sampled with in_data
//   out_valid/out_ready        substituted state handshake
//   out_data                   substituted state, same byte mapping as in_data
//   busy                       high while a state is in flight or waiting for out_ready
//   sbox_i/sbox_inverse        byte and mode driven to the S-box
//   sbox_o                     S-box result, SBOX_LAT cycles after sbox_i
//
// Build option: define SUBBYTES_IDLE_ZERO_EN to drive 8'h00 on sbox_i in
// every cycle where no byte is issued, so secret bytes are not left parked
// on the S-box input.
module aes_subbytes_byte_sequencer #(
    parameter int unsigned SBOX_LAT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inverse,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic [7:0]   sbox_i,
    output logic         sbox_inverse,
    input  logic [7:0]   sbox_o
);

    localparam int unsigned TOK_W = SBOX_LAT + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [127:0]       lat_data;
    logic [3:0]         issue_cnt;
    logic               issue_done;
    logic [3:0]         collect_cnt;
    // tok[0] marks a valid byte on sbox_i; tok[TOK_W-1] marks a valid sbox_o
    logic [TOK_W-1:0]   tok;

    logic               accept_c;
    logic               issue_c;
    logic               collect_c;
    logic [7:0]         issue_byte_c;
    logic [7:0]         sbox_i_next_c;

    // Next-state and per-cycle control
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        issue_c    = 1'b0;
        collect_c  = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept_c   = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                issue_c   = !issue_done;
                collect_c = tok[TOK_W-1];
                if (collect_c && (collect_cnt == 4'd15)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Byte k lives at bit offset 8*(15-k); ~cnt equals 15-cnt for 4 bits
    always_comb begin
        issue_byte_c = lat_data[{~issue_cnt, 3'b000} +: 8];
    end

`ifdef SUBBYTES_IDLE_ZERO_EN
    always_comb begin
        sbox_i_next_c = issue_c ? issue_byte_c : 8'h00;
    end
`else
    always_comb begin
        sbox_i_next_c = issue_c ? issue_byte_c : sbox_i;
    end
`endif

    // State, counters, token pipe and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            in_ready     <= 1'b0;
            busy         <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            sbox_i       <= '0;
            sbox_inverse <= 1'b0;
            lat_data     <= '0;
            issue_cnt    <= '0;
            issue_done   <= 1'b0;
            collect_cnt  <= '0;
            tok          <= '0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next == IDLE);
            busy      <= (state_next != IDLE);
            out_valid <= (state_next == DONE);
            sbox_i    <= sbox_i_next_c;
            tok       <= (tok << 1) | TOK_W'(issue_c);

            if (accept_c) begin
                lat_data     <= in_data;
                sbox_inverse <= in_inverse;
                issue_cnt    <= '0;
                issue_done   <= 1'b0;
                collect_cnt  <= '0;
            end

            // Counter parks at 15 with done set; no wrap-around
            if (issue_c) begin
                if (issue_cnt == 4'd15) begin
                    issue_done <= 1'b1;
                end else begin
                    issue_cnt <= issue_cnt + 4'd1;
                end
            end

            if (collect_c) begin
                out_data[{~collect_cnt, 3'b000} +: 8] <= sbox_o;
                if (collect_cnt != 4'd15) begin
                    collect_cnt <= collect_cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_subbytes_byte_sequencer.sv
// Bench for aes_subbytes_byte_sequencer: four instances with SBOX_LAT 0..3,
// each attached to a behavioural AES S-box built from GF(2^8) arithmetic.
`timescale 1ns/1ps
module tb_aes_subbytes_byte_sequencer;

    localparam int NI = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid     [NI];
    logic         in_ready     [NI];
    logic [127:0] in_data      [NI];
    logic         in_inverse   [NI];
    logic         out_valid    [NI];
    logic         out_ready    [NI];
    logic [127:0] out_data     [NI];
    logic         busy         [NI];
    logic [7:0]   sbox_i       [NI];
    logic         sbox_inverse [NI];
    logic [7:0]   sbox_o       [NI];

    int errors = 0;
    int checks = 0;
    logic [7:0] last_byte [NI];

    always #5 clk = ~clk;

    // ---------------- reference arithmetic ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        logic       hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b  = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] base;
        logic [7:0] e;
        r = 8'h01; base = x; e = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gf_mul(r, base);
            base = gf_mul(base, base);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x};
        t = t << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x, input logic inv);
        logic [7:0] b;
        if (!inv) begin
            b = gf_inv(x);
            return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
        end
        b = rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [7:0] byte_of(input logic [127:0] s, input int k);
        return s[127-8*k -: 8];
    endfunction

    function automatic logic [127:0] sub_state(input logic [127:0] s, input logic inv);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = sbox_calc(s[127-8*k -: 8], inv);
        return r;
    endfunction

    // Expected sbox_i in a cycle where no byte is issued
    function automatic logic [7:0] idle_sbox(input logic [7:0] last);
`ifdef SUBBYTES_IDLE_ZERO_EN
        return 8'h00 & last;
`else
        return last;
`endif
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- DUTs and attached S-box models ----------------
    for (genvar g = 0; g < NI; g++) begin : g_dut
        aes_subbytes_byte_sequencer #(.SBOX_LAT(g)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .in_valid     (in_valid[g]),
            .in_ready     (in_ready[g]),
            .in_data      (in_data[g]),
            .in_inverse   (in_inverse[g]),
            .out_valid    (out_valid[g]),
            .out_ready    (out_ready[g]),
            .out_data     (out_data[g]),
            .busy         (busy[g]),
            .sbox_i       (sbox_i[g]),
            .sbox_inverse (sbox_inverse[g]),
            .sbox_o       (sbox_o[g])
        );
        if (g == 0) begin : g_comb
            assign sbox_o[g] = sbox_calc(sbox_i[g], sbox_inverse[g]);
        end else begin : g_pipe
            // Not reset: stale results keep flowing out after a reset
            logic [7:0] pipe [g];
            always @(posedge clk) begin
                pipe[0] <= sbox_calc(sbox_i[g], sbox_inverse[g]);
                for (int i = 1; i < g; i++) pipe[i] <= pipe[i-1];
            end
            assign sbox_o[g] = pipe[g-1];
        end
    end

    // ---------------- drivers / monitors ----------------
    // Wait at negedges for in_valid&in_ready, then step past the accept edge
    // so the caller stands at the negedge of cycle 0.
    task automatic wait_accept(input int d, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (in_ready[d] === 1'b1 && in_valid[d] === 1'b1) begin
                @(posedge clk);
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_valid(input int d, output int c);
        c = -1;
        for (int n = 0; n < 60; n++) begin
            if (out_valid[d] === 1'b1) begin
                c = n;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic handshake(input int d, input int delay);
        repeat (delay) @(negedge clk);
        out_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[d] = 1'b0;
    endtask

    // Send one state and observe until out_valid; returns mismatch counts
    task automatic run_one(input int d, input logic [127:0] data, input logic inv,
                           output int c_valid, output int sbi_bad, output int inv_bad,
                           output int ctl_bad, output logic [127:0] got);
        bit ok;
        logic [7:0] exp_sbi;
        logic [7:0] prev;
        sbi_bad = 0; inv_bad = 0; ctl_bad = 0; c_valid = -1; got = '0;
        prev = last_byte[d];
        in_data[d] = data; in_inverse[d] = inv; in_valid[d] = 1'b1;
        wait_accept(d, ok);
        in_valid[d] = 1'b0; in_data[d] = rnd128(); in_inverse[d] = ~inv;
        if (ok) begin
            for (int c = 0; c < 60; c++) begin
                if (c >= 1 && c <= 16) exp_sbi = byte_of(data, c - 1);
                else if (c == 0)       exp_sbi = idle_sbox(prev);
                else                   exp_sbi = idle_sbox(byte_of(data, 15));
                if (sbox_i[d] !== exp_sbi) sbi_bad++;
                if (out_valid[d] === 1'b1) begin
                    c_valid = c;
                    got = out_data[d];
                    break;
                end
                if (sbox_inverse[d] !== inv) inv_bad++;
                if (in_ready[d] !== 1'b0 || busy[d] !== 1'b1) ctl_bad++;
                @(negedge clk);
            end
        end
        last_byte[d] = byte_of(data, 15);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        for (int d = 0; d < NI; d++) begin
            in_valid[d] = 1'b0; in_data[d] = '0; in_inverse[d] = 1'b0; out_ready[d] = 1'b0;
            last_byte[d] = 8'h00;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < NI; d++) begin
            checks++;
            if (in_ready[d] !== 1'b0 || out_valid[d] !== 1'b0 || busy[d] !== 1'b0 ||
                out_data[d] !== '0 || sbox_i[d] !== 8'h00 || sbox_inverse[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: rdy=%b ov=%b busy=%b od=%h si=%h inv=%b, all required 0",
                         d, in_ready[d], out_valid[d], busy[d], out_data[d], sbox_i[d], sbox_inverse[d]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < NI; d++) begin
            checks++;
            if (in_ready[d] !== 1'b1 || busy[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_release[%0d]: in_ready=%b busy=%b, required 1/0", d, in_ready[d], busy[d]);
            end
        end
    endtask

    // Shared result checks for a completed run_one call
    task automatic check_run(input string name, input int d, input int c, input int c_exp,
                             input logic [127:0] got, input logic [127:0] exp,
                             input int sbi_bad, input int inv_bad, input int ctl_bad);
        checks++;
        if (c !== c_exp) begin
            errors++;
            $display("FAIL %s latency[%0d]: out_valid at cycle %0d, required %0d", name, d, c, c_exp);
        end
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s data[%0d]: got %h required %h", name, d, got, exp);
        end
        checks++;
        if (sbi_bad !== 0) begin
            errors++;
            $display("FAIL %s sbox_i[%0d]: %0d bad cycles, required 0", name, d, sbi_bad);
        end
        checks++;
        if (inv_bad !== 0 || ctl_bad !== 0) begin
            errors++;
            $display("FAIL %s run_ctl[%0d]: inverse bad=%0d ready/busy bad=%0d, required 0/0",
                     name, d, inv_bad, ctl_bad);
        end
    endtask

    task automatic test_forward();
        int c, sb, ib, cb;
        logic [127:0] got;
        run_one(0, 128'h00112233445566778899aabbccddeeff, 1'b0, c, sb, ib, cb, got);
        check_run("forward", 0, c, 17, got, 128'h638293c31bfc33f5c4eeacea4bc12816, sb, ib, cb);
        handshake(0, 0);
        checks++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL forward_return_idle: in_ready=%b out_valid=%b, required 1/0", in_ready[0], out_valid[0]);
        end
    endtask

    task automatic test_inverse();
        int c, sb, ib, cb;
        logic [127:0] got;
        run_one(2, 128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1, c, sb, ib, cb, got);
        check_run("inverse", 2, c, 19, got, 128'h00112233445566778899aabbccddeeff, sb, ib, cb);
        handshake(2, 0);
    endtask

    task automatic test_backpressure();
        int c, sb, ib, cb, bad;
        logic [127:0] got;
        logic [127:0] d_in;
        logic [127:0] exp;
        d_in = rnd128();
        exp  = sub_state(d_in, 1'b0);
        run_one(1, d_in, 1'b0, c, sb, ib, cb, got);
        check_run("bp_first", 1, c, 18, got, exp, sb, ib, cb);
        bad = 0;
        for (int h = 0; h < 10; h++) begin
            if (h == 3) begin
                in_data[1] = '0; in_inverse[1] = 1'b0; in_valid[1] = 1'b1;
            end
            if (out_data[1] !== exp || out_valid[1] !== 1'b1 || in_ready[1] !== 1'b0 ||
                busy[1] !== 1'b1 || sbox_i[1] !== idle_sbox(byte_of(d_in, 15))) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL bp_hold: %0d cycles with changed data/handshake, required 0", bad);
        end
        handshake(1, 0);
        // in_valid is still high with the all-zero state
        run_one(1, '0, 1'b0, c, sb, ib, cb, got);
        check_run("bp_zero", 1, c, 18, got, {16{8'h63}}, sb, ib, cb);
        handshake(1, 0);
    endtask

    task automatic test_back_to_back();
        bit ok;
        int c;
        logic [127:0] a_in, b_in;
        logic ia, ib;
        a_in = rnd128(); b_in = rnd128();
        ia = 1'($urandom_range(0, 1)); ib = 1'($urandom_range(0, 1));
        in_data[3] = a_in; in_inverse[3] = ia; in_valid[3] = 1'b1;
        wait_accept(3, ok);
        in_data[3] = b_in; in_inverse[3] = ib;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_accept_a: accepted=%0d required 1", ok);
        end
        wait_valid(3, c);
        checks++;
        if (c !== 20 || out_data[3] !== sub_state(a_in, ia)) begin
            errors++;
            $display("FAIL b2b_first: cycle %0d data %h, required 20 %h", c, out_data[3], sub_state(a_in, ia));
        end
        out_ready[3] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[3] = 1'b0;
        checks++;
        if (in_ready[3] !== 1'b1 || out_valid[3] !== 1'b0 || busy[3] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: in_ready=%b out_valid=%b busy=%b, required 1/0/0",
                     in_ready[3], out_valid[3], busy[3]);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid[3] = 1'b0;
        checks++;
        if (busy[3] !== 1'b1 || in_ready[3] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept_b: busy=%b in_ready=%b, required 1/0", busy[3], in_ready[3]);
        end
        wait_valid(3, c);
        checks++;
        if (c !== 20 || out_data[3] !== sub_state(b_in, ib)) begin
            errors++;
            $display("FAIL b2b_second: cycle %0d data %h, required 20 %h", c, out_data[3], sub_state(b_in, ib));
        end
        handshake(3, 1);
        last_byte[3] = byte_of(b_in, 15);
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        int c, sb, ib, cb, bad;
        logic [127:0] got;
        logic [127:0] n_in;
        in_data[3] = rnd128(); in_inverse[3] = 1'b1; in_valid[3] = 1'b1;
        wait_accept(3, ok);
        in_valid[3] = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready[3] !== 1'b0 || out_valid[3] !== 1'b0 || busy[3] !== 1'b0 ||
            out_data[3] !== '0 || sbox_i[3] !== 8'h00 || sbox_inverse[3] !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset_outputs: rdy=%b ov=%b busy=%b od=%h si=%h inv=%b, all required 0",
                     in_ready[3], out_valid[3], busy[3], out_data[3], sbox_i[3], sbox_inverse[3]);
        end
        rst_n = 1'b1;
        for (int d = 0; d < NI; d++) last_byte[d] = 8'h00;
        @(negedge clk);
        bad = 0;
        for (int h = 0; h < 30; h++) begin
            if (out_valid[3] !== 1'b0 || busy[3] !== 1'b0 || in_ready[3] !== 1'b1) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL midrun_no_output: %0d cycles busy/valid after reset, required 0", bad);
        end
        n_in = rnd128();
        run_one(3, n_in, 1'b0, c, sb, ib, cb, got);
        check_run("midrun_next", 3, c, 20, got, sub_state(n_in, 1'b0), sb, ib, cb);
        handshake(3, 0);
    endtask

    task automatic test_random();
        int d, c, sb, ib, cb;
        logic [127:0] got;
        logic [127:0] data;
        logic inv;
        for (int it = 0; it < 8; it++) begin
            d    = $urandom_range(0, NI - 1);
            data = rnd128();
            inv  = 1'($urandom_range(0, 1));
            run_one(d, data, inv, c, sb, ib, cb, got);
            check_run("random", d, c, 17 + d, got, sub_state(data, inv), sb, ib, cb);
            handshake(d, $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_inverse();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
